// File: rtl/fd_defs_pkg.sv
// ----------------------------------------------------------------------------
// fd_defs_pkg
// Shared decode constants for the F/D branch controller: opcode values,
// REGIMM rt-field codes, next-PC select encodings and the reset PC.
// Optional feature macro: BRANCH_LIKELY_EN (the beql/bnel opcodes are always
// defined here; only the decoder decides whether they are recognised).
// ----------------------------------------------------------------------------
package fd_defs_pkg;

  localparam logic [5:0] OP_REGIMM = 6'b000001;
  localparam logic [5:0] OP_J      = 6'b000010;
  localparam logic [5:0] OP_JAL    = 6'b000011;
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_BNE    = 6'b000101;
  localparam logic [5:0] OP_BEQL   = 6'b010100;
  localparam logic [5:0] OP_BNEL   = 6'b010101;

  // rt-field sub-opcodes under REGIMM
  localparam logic [4:0] RT_BLTZ = 5'b00000;
  localparam logic [4:0] RT_BGEZ = 5'b00001;

  // Next-PC select; remaining 4-bit codes are reserved and never produced.
  typedef enum logic [3:0] {
    PCSEL_SEQ = 4'd0,
    PCSEL_BR  = 4'd1,
    PCSEL_JMP = 4'd2
  } pcsel_e;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;

endpackage

// File: rtl/fd_branch_ctrl_if.sv
// ----------------------------------------------------------------------------
// fd_branch_ctrl_if
// Bundle between fetch/hazard logic (master) and the F/D branch controller
// (slave).
//   master drives : F_PC, F_Instr, stall, D_rsData, D_rtData
//   slave drives  : D_PC, D_Instr, D_valid, D_PCsel, condition,
//                   D_extImm, D_index
// ----------------------------------------------------------------------------
interface fd_branch_ctrl_if;

  logic [31:0] F_PC;
  logic [31:0] F_Instr;
  logic        stall;
  logic [31:0] D_rsData;
  logic [31:0] D_rtData;

  logic [31:0] D_PC;
  logic [31:0] D_Instr;
  logic        D_valid;
  logic [3:0]  D_PCsel;
  logic [1:0]  condition;
  logic [31:0] D_extImm;
  logic [25:0] D_index;

  modport master (
    output F_PC, F_Instr, stall, D_rsData, D_rtData,
    input  D_PC, D_Instr, D_valid, D_PCsel, condition, D_extImm, D_index
  );

  modport slave (
    input  F_PC, F_Instr, stall, D_rsData, D_rtData,
    output D_PC, D_Instr, D_valid, D_PCsel, condition, D_extImm, D_index
  );

endinterface

// File: rtl/branch_cmp.sv
// ----------------------------------------------------------------------------
// branch_cmp
// Pure combinational branch resolution for the D stage.
// Ports:
//   i_rs, i_rt     : forwarded register operands
//   i_opcode       : Instr[31:26]
//   i_rt_field     : Instr[20:16] (REGIMM sub-opcode)
//   o_taken        : conditional branch is taken (validity applied by caller)
//   o_condition    : {rs negative, rs == rt}, independent of opcode
// Optional feature macro: BRANCH_LIKELY_EN adds beql/bnel.
// ----------------------------------------------------------------------------
module branch_cmp
  import fd_defs_pkg::*;
(
  input  logic [31:0] i_rs,
  input  logic [31:0] i_rt,
  input  logic [5:0]  i_opcode,
  input  logic [4:0]  i_rt_field,
  output logic        o_taken,
  output logic [1:0]  o_condition
);

  logic w_eq;
  logic w_neg;

  assign w_eq        = (i_rs == i_rt);
  assign w_neg       = i_rs[31];
  assign o_condition = {w_neg, w_eq};

  always_comb begin
    // NOTE: default assignment up front so no path leaves o_taken unassigned
    // (an unassigned path in always_comb would infer a latch).
    o_taken = 1'b0;
    case (i_opcode)
      OP_BEQ:    o_taken = w_eq;
      OP_BNE:    o_taken = ~w_eq;
      OP_REGIMM: begin
        if (i_rt_field == RT_BGEZ)      o_taken = ~w_neg;
        else if (i_rt_field == RT_BLTZ) o_taken = w_neg;
      end
`ifdef BRANCH_LIKELY_EN
      OP_BEQL:   o_taken = w_eq;
      OP_BNEL:   o_taken = ~w_eq;
`endif
      default:   o_taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/fd_branch_ctrl.sv
// ----------------------------------------------------------------------------
// fd_branch_ctrl
// F/D pipeline register plus D-stage control-flow decode. Captures the fetch
// PC/instruction, then decodes the held instruction into a next-PC select,
// compare flags, sign-extended immediate and jump index. Branches resolve in
// D with a single MIPS delay slot.
// Ports:
//   clk   : system clock
//   reset : synchronous, active-high
//   bus   : fd_branch_ctrl_if.slave (F inputs, stall, forwarded rs/rt in;
//           D_PC/D_Instr/D_valid/D_PCsel/condition/D_extImm/D_index out)
// Optional feature macro: BRANCH_LIKELY_EN -- beql/bnel with delay-slot
// squash when not taken.
// ----------------------------------------------------------------------------
module fd_branch_ctrl
  import fd_defs_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = fd_defs_pkg::RESET_PC,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input logic             clk,
  input logic             reset,
  fd_branch_ctrl_if.slave bus
);

  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic        r_valid;

  logic [5:0]  w_opcode;
  logic        w_taken;
  logic [1:0]  w_condition;
  pcsel_e      w_pcsel;

  assign w_opcode = r_instr[31:26];

  branch_cmp u_branch_cmp (
    .i_rs        (bus.D_rsData),
    .i_rt        (bus.D_rtData),
    .i_opcode    (w_opcode),
    .i_rt_field  (r_instr[20:16]),
    .o_taken     (w_taken),
    .o_condition (w_condition)
  );

`ifdef BRANCH_LIKELY_EN
  // Set while D holds a squashed delay slot; held through stalls.
  logic r_nullify;
  logic w_kill_slot;

  // A valid, not-taken branch-likely in D kills whatever F presents at the
  // next advancing edge, i.e. its delay slot.
  assign w_kill_slot = r_valid && !w_taken && !r_nullify &&
                       ((w_opcode == OP_BEQL) || (w_opcode == OP_BNEL));
`endif

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    if (reset) begin
      r_pc      <= RESET_PC;
      r_instr   <= NOP_INSTR;
      r_valid   <= 1'b0;
`ifdef BRANCH_LIKELY_EN
      r_nullify <= 1'b0;
`endif
    end else if (!bus.stall) begin
`ifdef BRANCH_LIKELY_EN
      if (w_kill_slot) begin
        r_pc      <= bus.F_PC;
        r_instr   <= NOP_INSTR;
        r_valid   <= 1'b0;
        r_nullify <= 1'b1;
      end else begin
        r_pc      <= bus.F_PC;
        r_instr   <= bus.F_Instr;
        r_valid   <= 1'b1;
        r_nullify <= 1'b0;
      end
`else
      r_pc    <= bus.F_PC;
      r_instr <= bus.F_Instr;
      r_valid <= 1'b1;
`endif
    end
  end

  always_comb begin
    w_pcsel = PCSEL_SEQ;
    if (r_valid) begin
      if ((w_opcode == OP_J) || (w_opcode == OP_JAL)) w_pcsel = PCSEL_JMP;
      else if (w_taken)                               w_pcsel = PCSEL_BR;
    end
  end

  assign bus.D_PC      = r_pc;
  assign bus.D_Instr   = r_instr;
  assign bus.D_valid   = r_valid;
  assign bus.D_PCsel   = w_pcsel;
  assign bus.condition = w_condition;
  assign bus.D_extImm  = {{16{r_instr[15]}}, r_instr[15:0]};
  assign bus.D_index   = r_instr[25:0];

endmodule

// File: tb/tb_fd_branch_ctrl.sv
// ----------------------------------------------------------------------------
// tb_fd_branch_ctrl
// Self-checking bench for fd_branch_ctrl. Each step drives F inputs, stall,
// reset and forwarded operands, pushes the expected D-stage view onto a
// scoreboard, and after the clock edge pops and compares it.
// Honors BRANCH_LIKELY_EN the same way as the design.
// ----------------------------------------------------------------------------
module tb_fd_branch_ctrl;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  fd_branch_ctrl_if bus ();

  fd_branch_ctrl #(
    .RESET_PC  (32'h0000_3000),
    .NOP_INSTR (32'h0000_0000)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        valid;
    logic [3:0]  pcsel;
    logic [1:0]  cond;
    logic [31:0] ext;
    logic [25:0] index;
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_fails  = 0;

  // Bench-side model of the F/D register
  logic [31:0] m_pc    = 32'h0;
  logic [31:0] m_instr = 32'h0;
  logic        m_valid = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Not-taken branch-likely currently in the model's D slot?
  function automatic logic likely_not_taken(input logic [31:0] rs,
                                            input logic [31:0] rt);
`ifdef BRANCH_LIKELY_EN
    logic [5:0] op;
    op = m_instr[31:26];
    return m_valid && (((op == 6'h14) && (rs != rt)) ||
                       ((op == 6'h15) && (rs == rt)));
`else
    return 1'b0;
`endif
  endfunction

  task automatic step(input string tag, input logic rst, input logic st,
                      input logic [31:0] pc, input logic [31:0] instr,
                      input logic [31:0] rs, input logic [31:0] rt,
                      input logic [3:0] e_pcsel, input logic [1:0] e_cond);
    exp_t e;
    exp_t got;
    logic kill;
    reset         = rst;
    bus.stall     = st;
    bus.F_PC      = pc;
    bus.F_Instr   = instr;
    bus.D_rsData  = rs;
    bus.D_rtData  = rt;
    kill = likely_not_taken(rs, rt);
    if (rst) begin
      m_pc = 32'h0000_3000; m_instr = 32'h0; m_valid = 1'b0;
    end else if (!st) begin
      if (kill) begin
        m_pc = pc; m_instr = 32'h0; m_valid = 1'b0;
      end else begin
        m_pc = pc; m_instr = instr; m_valid = 1'b1;
      end
    end
    e.pc    = m_pc;
    e.instr = m_instr;
    e.valid = m_valid;
    e.pcsel = e_pcsel;
    e.cond  = e_cond;
    e.ext   = {{16{m_instr[15]}}, m_instr[15:0]};
    e.index = m_instr[25:0];
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    check({tag, ".pc"},    bus.D_PC,             got.pc);
    check({tag, ".instr"}, bus.D_Instr,          got.instr);
    check({tag, ".valid"}, {31'b0, bus.D_valid}, {31'b0, got.valid});
    check({tag, ".pcsel"}, {28'b0, bus.D_PCsel}, {28'b0, got.pcsel});
    check({tag, ".cond"},  {30'b0, bus.condition}, {30'b0, got.cond});
    check({tag, ".ext"},   bus.D_extImm,         got.ext);
    check({tag, ".index"}, {6'b0, bus.D_index},  {6'b0, got.index});
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] bl_pcsel;
`ifdef BRANCH_LIKELY_EN
    bl_pcsel = 4'd1;
`else
    bl_pcsel = 4'd0;
`endif

    // Reset held two cycles with a branch on F
    step("rst0", 1, 0, 32'h100, 32'h1022_0004, 0, 0, 0, 2'b01);
    step("rst1", 1, 0, 32'h104, 32'h1022_0004, 0, 0, 0, 2'b01);

    // beq taken / not taken
    step("beq_t",  0, 0, 32'h1000, 32'h1022_0004, 5, 5, 1, 2'b01);
    step("beq_nt", 0, 0, 32'h1004, 32'h1022_0004, 5, 6, 0, 2'b00);

    // REGIMM sign tests
    step("bltz_t",  0, 0, 32'h1008, 32'h0420_FFFC, 32'hFFFF_FFFF, 0, 1, 2'b10);
    step("bltz_nt", 0, 0, 32'h100C, 32'h0420_FFFC, 0, 0, 0, 2'b01);
    step("bgez_t",  0, 0, 32'h1010, 32'h0421_FFFC, 0, 0, 1, 2'b01);
    step("bgez_nt", 0, 0, 32'h1014, 32'h0421_FFFC, 32'hFFFF_FFFF, 5, 0, 2'b10);
    step("bne_t",   0, 0, 32'h1018, 32'h1422_0004, 1, 2, 1, 2'b00);

    // Jumps and a plain ALU instruction
    step("j",     0, 0, 32'h101C, 32'h0800_0C10, 0, 0, 2, 2'b01);
    step("jal",   0, 0, 32'h1020, 32'h0C00_0C10, 0, 0, 2, 2'b01);
    step("addiu", 0, 0, 32'h1024, 32'h2401_0001, 3, 3, 0, 2'b01);

    // Stall holds D while F keeps changing, then releases
    step("st_ld", 0, 0, 32'h2000, 32'h1022_0004, 7, 7, 1, 2'b01);
    for (int i = 0; i < 3; i++)
      step("stall", 0, 1, 32'h2004 + 32'(4 * i), 32'h0800_0001 + 32'(i), 7, 7, 1, 2'b01);
    step("st_rel", 0, 0, 32'h2010, 32'h2401_0001, 7, 7, 0, 2'b01);

    // beql not taken: delay slot squashed when the feature is enabled
    step("beql_nt", 0, 0, 32'h3000, 32'h5022_0004, 1, 2, 0, 2'b00);
    step("slot_nt", 0, 0, 32'h3004, 32'h2401_0001, 1, 2, 0, 2'b00);
    step("after",   0, 0, 32'h3008, 32'h2401_0001, 1, 2, 0, 2'b00);

    // beql taken: delay slot loads normally
    step("beql_t", 0, 0, 32'h300C, 32'h5022_0004, 3, 3, bl_pcsel, 2'b01);
    step("slot_t", 0, 0, 32'h3010, 32'h2401_0001, 3, 3, 0, 2'b01);

    // bnel not taken with a stall before the delay slot arrives
    step("bnel_nt", 0, 0, 32'h3014, 32'h5422_0004, 4, 4, 0, 2'b01);
    step("bnel_st", 0, 1, 32'h3018, 32'h2401_0001, 4, 4, 0, 2'b01);
    step("slot_b",  0, 0, 32'h3018, 32'h2401_0001, 4, 4, 0, 2'b01);

    // Reset during a stall wins
    step("pre_rst", 0, 0, 32'h4000, 32'h1022_0004, 9, 9, 1, 2'b01);
    step("rst_st",  1, 1, 32'h4004, 32'h1022_0004, 9, 9, 0, 2'b01);
    step("post",    0, 0, 32'h4008, 32'h0800_0C10, 9, 8, 2, 2'b00);

    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/fd_branch_ctrl.md
Name: fd_branch_ctrl

Overview:
- Decode-side counterpart of the fetch stage: captures F_PC/F_Instr into the F/D pipeline register and decodes the held instruction for control flow.
- Returns D_PCsel, condition, D_extImm and D_index to the fetch stage's next-PC logic.
- Resolves branches in D; MIPS single delay slot.
- Sits between the fetch stage and the D-stage register file / hazard unit.

Parameters:
- RESET_PC, 32'h0000_3000, D_PC value after reset.
- NOP_INSTR, 32'h0000_0000, D_Instr value after reset or nullify.

Ports:
- clk  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- F_PC  in  32  fetch-stage PC.
- F_Instr  in  32  fetch-stage instruction.
- stall  in  1  hazard unit: hold the F/D register.
- D_rsData  in  32  forwarded rs value for compare.
- D_rtData  in  32  forwarded rt value for compare.
- D_PC  out  32  registered PC of D instruction.
- D_Instr  out  32  registered D instruction.
- D_valid  out  1  D holds a real, non-nullified instruction.
- D_PCsel  out  4  next-PC select: 0 = PC+4, 1 = branch target, 2 = jump (index); others reserved, never driven.
- condition  out  2  {rs<0 signed, rs==rt} for the current D instruction.
- D_extImm  out  32  sign-extended Instr[15:0].
- D_index  out  26  Instr[25:0].

Behaviour:
- F/D register update on posedge clk, priority: reset > stall > nullify > load.
  - reset: D_PC=RESET_PC, D_Instr=NOP_INSTR, D_valid=0.
  - stall: all registered values held, including the nullify-pending flag.
  - load: D_PC<=F_PC, D_Instr<=F_Instr, D_valid<=1.
- Decode is combinational from the registered D_Instr; D outputs are valid one cycle after F presents them.
- D_extImm = {{16{Instr[15]}}, Instr[15:0]}.
- D_index = Instr[25:0].
- condition = {D_rsData[31], D_rsData==D_rtData}; always computed, regardless of opcode.
- Taken rules (D_PCsel=1 only when taken):
  - beq (000100): rs==rt.
  - bne (000101): rs!=rt.
  - REGIMM (000001), rt=00001 bgez: rs>=0.
  - REGIMM (000001), rt=00000 bltz: rs<0.
- j (000010) and jal (000011): D_PCsel=2 unconditionally.
- Every other opcode, or D_valid=0: D_PCsel=0.
- Reset output values: D_PC=RESET_PC, D_Instr=0, D_valid=0, D_PCsel=0, D_extImm=0, D_index=0.
  - condition reflects its inputs only; it is not forced by reset.
- During stall the outputs are still driven from the held instruction. Freezing the fetch PC is the hazard unit's responsibility, not this block's.
- Delay slot: the instruction in F while a branch is in D is always loaded. Without the optional feature it is never squashed.
- Reset mid-stall or with a nullify pending: reset wins; the pending flag is cleared.

Optional Feature:
- Macro: BRANCH_LIKELY_EN.
- Defined:
  - Also decode beql (010100) and bnel (010101); taken rules as beq/bne.
  - When one of these is in D, valid, not taken and stall=0: set a one-bit nullify flag.
  - Next non-stalled edge: load NOP_INSTR with D_valid=0 and D_PC<=F_PC instead of the delay slot; clear the flag.
  - Taken: delay slot loads normally.
- Undefined: these opcodes decode as "other" (D_PCsel=0); no nullify flag or logic exists.

Decomposition:
- Shared package fd_defs_pkg:
  - opcode constants: OP_BEQ, OP_BNE, OP_REGIMM, OP_J, OP_JAL, OP_BEQL, OP_BNEL.
  - REGIMM rt codes.
  - PCSEL_SEQ/PCSEL_BR/PCSEL_JMP encodings.
  - RESET_PC.
- One sub-module: branch_cmp. Pure combinational; inputs rs, rt, opcode, rt-field; outputs taken and condition.

Test Plan:
- Reset: assert reset 2 cycles with F_Instr=0x10220004 -> D_PC=0x00003000, D_Instr=0, D_valid=0, D_PCsel=0.
- Branch taken: load beq 0x10220004, rs=rt=5 -> D_PCsel=1, condition=2'b01, D_extImm=0x00000004. Repeat with rt=6 -> D_PCsel=0, condition=2'b00.
- Regimm sign: bltz 0x0420FFFC with rs=0xFFFFFFFF -> D_PCsel=1, condition[1]=1, D_extImm=0xFFFFFFFC. Same instruction with rs=0 -> D_PCsel=0.
- Jump: F_Instr=0x08000C10 -> D_PCsel=2, D_index=0x0000C10. jal 0x0C000C10 -> same.
- Stall: load beq, then stall 3 cycles while F_PC/F_Instr change -> D_PC/D_Instr and D_PCsel unchanged throughout. Release -> next F values load.
- BRANCH_LIKELY_EN: beql 0x50220004 not taken (rs=1, rt=2), delay slot 0x24010001 -> next cycle D_Instr=0, D_valid=0. Taken case -> delay slot loads with D_valid=1.
